bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Two-master arbiter for the shared system bus; sits between the masters and the address decoder / master-side muxes.
- Grants bus ownership to one master at a time using round-robin priority.
- Drives the master-select used by the address/wdata/control muxes feeding the address decoder.
- Holds the grant until the owning master releases its request.

Parameters:
- TIMEOUT, 64, maximum consecutive grant cycles before forced hand-over (used only with the optional feature); legal range 2..255.
- CNT_WIDTH, 8, width of the hold counter; must satisfy 2^CNT_WIDTH > TIMEOUT.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- breq1  input  1  bus request from master 1; held high for the whole transaction.
- breq2  input  1  bus request from master 2; held high for the whole transaction.
- bgrant1  output  1  grant to master 1; registered.
- bgrant2  output  1  grant to master 2; registered.
- msel  output  1  master-mux select: 0 = master 1, 1 = master 2; registered.
- bus_busy  output  1  high while either grant is high; registered.
- arb_timeout  output  1  one-cycle pulse on a forced hand-over; registered.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). While rst is sampled high, every output is 0 on that edge, state = IDLE, last_served = M2 (so M1 wins the first tie), and the hold counter = 0.
- States:
  - IDLE: no grant.
  - GNT1: bgrant1=1, msel=0.
  - GNT2: bgrant2=1, msel=1.
- bgrant1 and bgrant2 are never high together. bus_busy = bgrant1 | bgrant2, registered in the same flop stage.
- IDLE transitions, evaluated at each edge:
  - Only breq1 high -> GNT1.
  - Only breq2 high -> GNT2.
  - Both high -> grant goes to the master that is not last_served.
  - Neither high -> stay in IDLE.
- Grant latency: a request sampled at edge N in IDLE gives a grant visible after edge N (1 cycle).
- GNTx transitions:
  - Stay while breqx is high.
  - When breqx is sampled low, the grant drops at that edge and last_served := x.
  - In the same edge, if the other master is requesting, go directly to the other GNT state (zero idle cycles). Otherwise go to IDLE.
- msel changes only on grant transitions. In IDLE, msel holds its last value (0 after reset).
- A request dropped before it is granted is simply ignored; no request is latched.
- A grant is never revoked while its request stays high, except under the optional feature.
- rst asserted mid-grant: the grant drops at that edge; the owner must re-arbitrate after reset.
- Hold counter: cleared on every grant transition, +1 each cycle in GNT1/GNT2, saturates at 2^CNT_WIDTH-1. Only observable through the optional feature.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro defined:
  - In GNTx, if the hold counter reaches TIMEOUT-1 and the other master is requesting, the next edge forces a switch to the other GNT state.
  - last_served := x, and arb_timeout pulses high for exactly 1 cycle, aligned with the new grant.
  - The preempted master keeps breq high and waits; it is re-granted by the normal rules.
  - If the other master is not requesting, the current grant continues and the counter saturates. No pulse is generated.
- Without the macro: no forced hand-over, and arb_timeout is tied to 0.

Test Plan:
- Reset: hold rst=1 for 2 cycles with breq1=breq2=1 -> all outputs 0. After rst falls, bgrant1=1 and msel=0 after 1 edge.
- Single master: breq2=1 for 5 cycles, then 0 -> bgrant2 high for exactly 5 cycles starting 1 cycle after the request, msel=1, bus_busy follows. IDLE on the edge where breq2 is sampled low.
- Round-robin: both held high, and each master drops its breq for 1 cycle after 3 cycles of ownership -> grants alternate M1, M2, M1, ... with no idle cycle between owners and never both high.
- Tie after service: M1 served and released, then breq1 and breq2 rise together in IDLE -> M2 granted first.
- Reset mid-grant: rst pulsed during GNT2 with breq2 still high -> bgrant2=0 at that edge. After rst falls with both requesting -> M1 granted.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT=4): breq1 held, breq2 rises at cycle 1 of the grant -> bgrant1 lasts 4 cycles, then bgrant2=1 and arb_timeout pulses for 1 cycle. Without the macro, bgrant1 stays high indefinitely and arb_timeout stays 0.

Source files
------------

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter
//  Description : Two-master round-robin bus arbiter. Grants ownership of the
//                shared system bus to one master at a time, holds the grant
//                until the owner drops its request, and drives the master-mux
//                select used ahead of the address decoder.
//
//  Ports       : clk         - system clock, rising edge
//                rst         - synchronous reset, active-high
//                breq1/2     - bus requests from master 1 / master 2
//                bgrant1/2   - registered grants (never both high)
//                msel        - registered mux select, 0 = M1, 1 = M2
//                bus_busy    - registered, high while either grant is high
//                arb_timeout - registered one-cycle pulse on forced hand-over
//
//  Options     : define ARB_TIMEOUT_EN to enable forced hand-over after
//                TIMEOUT consecutive grant cycles when the other master is
//                waiting. Without it arb_timeout is constant 0.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
    parameter int TIMEOUT   = 64,
    parameter int CNT_WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic breq1,
    input  logic breq2,
    output logic bgrant1,
    output logic bgrant2,
    output logic msel,
    output logic bus_busy,
    output logic arb_timeout
);

`ifdef ARB_TIMEOUT_EN
    localparam logic c_timeout_en = 1'b1;
`else
    localparam logic c_timeout_en = 1'b0;
`endif

    // Hold-counter value seen during the last permitted grant cycle.
    localparam logic [CNT_WIDTH-1:0] c_hold_limit = CNT_WIDTH'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GNT1 = 2'd1,
        S_GNT2 = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   r_last_served;  // 0 = M1 served last, 1 = M2
    logic                   w_next_last;
    logic                   w_force;        // forced hand-over this edge
    logic                   w_hold_max;
    logic                   w_next_msel;
    logic [CNT_WIDTH-1:0]   r_hold_cnt;
    logic                   r_bgrant1;
    logic                   r_bgrant2;
    logic                   r_msel;
    logic                   r_bus_busy;
    logic                   r_arb_timeout;

    assign w_hold_max = (r_hold_cnt >= c_hold_limit);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_next_last  = r_last_served;
        w_force      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (breq1 && breq2) begin
                    // Tie goes to whoever was not served last.
                    if (r_last_served) begin
                        w_next_state = S_GNT1;
                    end else begin
                        w_next_state = S_GNT2;
                    end
                end else if (breq1) begin
                    w_next_state = S_GNT1;
                end else if (breq2) begin
                    w_next_state = S_GNT2;
                end
            end

            S_GNT1: begin
                if (!breq1) begin
                    w_next_last = 1'b0;
                    if (breq2) begin
                        w_next_state = S_GNT2;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end else if (c_timeout_en && w_hold_max && breq2) begin
                    w_next_state = S_GNT2;
                    w_next_last  = 1'b0;
                    w_force      = 1'b1;
                end
            end

            S_GNT2: begin
                if (!breq2) begin
                    w_next_last = 1'b1;
                    if (breq1) begin
                        w_next_state = S_GNT1;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end else if (c_timeout_en && w_hold_max && breq1) begin
                    w_next_state = S_GNT1;
                    w_next_last  = 1'b1;
                    w_force      = 1'b1;
                end
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // msel follows the granted master and holds through IDLE.
    always_comb begin
        w_next_msel = r_msel;
        case (w_next_state)
            S_GNT1:  w_next_msel = 1'b0;
            S_GNT2:  w_next_msel = 1'b1;
            default: w_next_msel = r_msel;
        endcase
    end

    // ------------------------------------------------------------------------
    // State, counter and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_last_served <= 1'b1;
            r_hold_cnt    <= '0;
            r_bgrant1     <= 1'b0;
            r_bgrant2     <= 1'b0;
            r_msel        <= 1'b0;
            r_bus_busy    <= 1'b0;
            r_arb_timeout <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_last_served <= w_next_last;
            r_bgrant1     <= (w_next_state == S_GNT1);
            r_bgrant2     <= (w_next_state == S_GNT2);
            r_msel        <= w_next_msel;
            r_bus_busy    <= (w_next_state != S_IDLE);
            r_arb_timeout <= w_force;

            // Counts completed cycles of the current grant; restarts on any
            // change of owner and saturates rather than wrapping.
            if (w_next_state != r_state) begin
                r_hold_cnt <= '0;
            end else if ((r_state != S_IDLE) && (r_hold_cnt != {CNT_WIDTH{1'b1}})) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
        end
    end

    assign bgrant1     = r_bgrant1;
    assign bgrant2     = r_bgrant2;
    assign msel        = r_msel;
    assign bus_busy    = r_bus_busy;
    assign arb_timeout = r_arb_timeout;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_arbiter
//  Description : Self-checking bench for bus_arbiter. Directed scenarios
//                followed by random request traffic, all compared against a
//                behavioural owner/last-served model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

    localparam int TIMEOUT   = 4;
    localparam int CNT_WIDTH = 8;

`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    logic breq1;
    logic breq2;
    logic bgrant1;
    logic bgrant2;
    logic msel;
    logic bus_busy;
    logic arb_timeout;

    int errors = 0;
    int checks = 0;

    // Behavioural model: who owns the bus, who was served last, how many
    // cycles the current owner has held it, last msel, timeout pulse.
    int m_owner;   // 0 = nobody, 1 = M1, 2 = M2
    int m_last;    // 1 or 2
    int m_held;
    bit m_msel;
    bit m_to;

    string phase;

    bus_arbiter #(
        .TIMEOUT   (TIMEOUT),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .breq1       (breq1),
        .breq2       (breq2),
        .bgrant1     (bgrant1),
        .bgrant2     (bgrant2),
        .msel        (msel),
        .bus_busy    (bus_busy),
        .arb_timeout (arb_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int other(input int m);
        return (m == 1) ? 2 : 1;
    endfunction

    task automatic model_update(input bit r, input bit b1, input bit b2);
        int  nxt;
        bit  req_owner;
        bit  req_other;
        m_to = 1'b0;
        if (r) begin
            m_owner = 0;
            m_last  = 2;
            m_held  = 0;
            m_msel  = 1'b0;
            return;
        end
        nxt = m_owner;
        if (m_owner == 0) begin
            if (b1 && b2)  nxt = other(m_last);
            else if (b1)   nxt = 1;
            else if (b2)   nxt = 2;
        end else begin
            req_owner = (m_owner == 1) ? b1 : b2;
            req_other = (m_owner == 1) ? b2 : b1;
            if (!req_owner) begin
                m_last = m_owner;
                nxt    = req_other ? other(m_owner) : 0;
            end else if (TO_EN && (m_held >= TIMEOUT) && req_other) begin
                m_last = m_owner;
                nxt    = other(m_owner);
                m_to   = 1'b1;
            end
        end
        if (nxt != m_owner) m_held = (nxt != 0) ? 1 : 0;
        else if (nxt != 0)  m_held = m_held + 1;
        if (nxt == 1) m_msel = 1'b0;
        if (nxt == 2) m_msel = 1'b1;
        m_owner = nxt;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s/%s: observed=%b expected=%b at %0t", phase, tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("bgrant1",     bgrant1,     m_owner == 1);
        check("bgrant2",     bgrant2,     m_owner == 2);
        check("msel",        msel,        m_msel);
        check("bus_busy",    bus_busy,    m_owner != 0);
        check("arb_timeout", arb_timeout, m_to);
        check("exclusive",   bgrant1 & bgrant2, 1'b0);
    endtask

    // Apply inputs, take one edge, update the model, sample 1 ns later.
    task automatic step(input bit r, input bit b1, input bit b2);
        rst   = r;
        breq1 = b1;
        breq2 = b2;
        @(posedge clk);
        model_update(r, b1, b2);
        #1;
        check_all();
    endtask

    initial begin
        bit rb1;
        bit rb2;
        rst = 1'b1; breq1 = 1'b0; breq2 = 1'b0;
        m_owner = 0; m_last = 2; m_held = 0; m_msel = 1'b0; m_to = 1'b0;

        // Reset held with both requesting: everything low.
        phase = "reset";
        step(1, 1, 1);
        step(1, 1, 1);
        // First tie after reset goes to M1.
        step(0, 1, 1);
        check("first_tie_m1", bgrant1, 1'b1);
        step(0, 0, 0);
        step(0, 0, 0);

        // Single master M2 for 5 cycles.
        phase = "single";
        repeat (5) step(0, 0, 1);
        step(0, 0, 0);
        step(0, 0, 0);

        // Round robin: both requesting, owner drops for one cycle after 3.
        phase = "round_robin";
        for (int i = 0; i < 4; i++) begin
            repeat (3) step(0, 1, 1);
            if (m_owner == 1) step(0, 0, 1);
            else              step(0, 1, 0);
        end
        step(0, 0, 0);

        // Tie after M1 was served: M2 wins.
        phase = "tie_after_m1";
        step(0, 1, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        step(0, 1, 1);
        check("tie_m2", bgrant2, 1'b1);
        step(0, 0, 0);

        // Reset in the middle of a GNT2.
        phase = "reset_mid_grant";
        step(0, 0, 1);
        step(0, 0, 1);
        step(1, 0, 1);
        check("rst_drops", bgrant2, 1'b0);
        step(0, 1, 1);
        check("post_rst_m1", bgrant1, 1'b1);
        step(0, 0, 0);

        // Long hold with the other master waiting (forced hand-over only
        // when the timeout feature is built in).
        phase = "timeout";
        step(0, 1, 0);
        repeat (10) step(0, 1, 1);
        step(0, 0, 0);
        step(0, 0, 0);

        // Random traffic with sticky requests and occasional resets.
        phase = "random";
        rb1 = 1'b0;
        rb2 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) rb1 = ~rb1;
            if ($urandom_range(0, 4) == 0) rb2 = ~rb2;
            step($urandom_range(0, 49) == 0, rb1, rb2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
